// File: rtl/axil_status_poller_pkg.sv
// Shared definitions for the AXI4-Lite status poller: response codes, FSM
// state encoding and the register address helper.
package axil_status_poller_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_EMIT
    } poll_state_t;

    // Byte address of register idx; wraps modulo 2^32 like the AXI address bus.
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/axil_status_poller_poll_timer.sv
// Free-running sweep interval timer: counts while enabled and not held,
// pulses expire for one cycle every POLL_CYCLES counted cycles.
module axil_status_poller_poll_timer #(
    parameter int unsigned POLL_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic hold,
    output logic expire
);

    localparam int unsigned        CNT_W    = $clog2(POLL_CYCLES);
    localparam logic [CNT_W-1:0]   TERMINAL = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             running;

    assign running = enable && !hold;
    assign expire  = running && (count_reg == TERMINAL);

    // Any pause (disabled or a sweep in flight) restarts the interval from zero.
    always_comb begin
        count_next = count_reg + CNT_ONE;
        if (!running || expire) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/axil_status_poller.sv
// AXI4-Lite read-only master that sweeps REG_COUNT consecutive 32-bit registers
// and streams each word out tagged with its index and read response.
module axil_status_poller
    import axil_status_poller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned POLL_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        trigger,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    output logic [2:0]  M_AXI_ARPROT,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic        M_AXI_RVALID,
    input  logic [1:0]  M_AXI_RRESP,
    output logic        M_AXI_RREADY,
    output logic [31:0] out_tdata,
    output logic [7:0]  out_index,
    output logic [1:0]  out_resp,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        busy,
    output logic [31:0] sweep_count,
    output logic [15:0] error_count
);

    localparam logic [7:0] LAST_IDX = 8'(REG_COUNT - 1);

    poll_state_t state_reg;
    logic [7:0]  idx_reg;
    logic [7:0]  idx_next;
    logic [31:0] araddr_reg;
    logic        arvalid_reg;
    logic        rready_reg;
    logic [31:0] tdata_reg;
    logic [7:0]  index_reg;
    logic [1:0]  resp_reg;
    logic        tlast_reg;
    logic        tvalid_reg;
    logic [31:0] sweep_count_reg;
    logic [15:0] error_count_reg;
    logic        pending_reg;
    logic        timer_expire;
    logic        sweep_start;

    axil_status_poller_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_poll_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .hold   (busy),
        .expire (timer_expire)
    );

    assign idx_next    = idx_reg + 8'd1;
    assign sweep_start = trigger || pending_reg || timer_expire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= '0;
            araddr_reg      <= '0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            tdata_reg       <= '0;
            index_reg       <= '0;
            resp_reg        <= RESP_OKAY;
            tlast_reg       <= 1'b0;
            tvalid_reg      <= 1'b0;
            sweep_count_reg <= '0;
            error_count_reg <= '0;
            pending_reg     <= 1'b0;
        end else begin
            // A trigger that arrives mid-sweep is remembered (one deep).
            if (trigger && (state_reg != ST_IDLE)) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (sweep_start) begin
                        pending_reg <= 1'b0;
                        idx_reg     <= '0;
                        araddr_reg  <= reg_addr(BASE_ADDR, 8'd0);
                        arvalid_reg <= 1'b1;
                        state_reg   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_reg <= 1'b0;
                        tdata_reg  <= M_AXI_RDATA;
                        resp_reg   <= M_AXI_RRESP;
                        index_reg  <= idx_reg;
                        tlast_reg  <= (idx_reg == LAST_IDX);
                        tvalid_reg <= 1'b1;
                        if (M_AXI_RRESP != RESP_OKAY) begin
                            error_count_reg <= sat_inc16(error_count_reg);
                        end
                        state_reg <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // The next read waits for the consumer, so stalls never lose words.
                    if (out_tready) begin
                        tvalid_reg <= 1'b0;
                        if (tlast_reg) begin
                            sweep_count_reg <= sweep_count_reg + 32'd1;
                            state_reg       <= ST_IDLE;
                        end else begin
                            idx_reg     <= idx_next;
                            araddr_reg  <= reg_addr(BASE_ADDR, idx_next);
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_ADDR;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_reg != ST_IDLE);
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_reg;
    assign out_tdata     = tdata_reg;
    assign out_index     = index_reg;
    assign out_resp      = resp_reg;
    assign out_tlast     = tlast_reg;
    assign out_tvalid    = tvalid_reg;
    assign sweep_count   = sweep_count_reg;
    assign error_count   = error_count_reg;

endmodule
